sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter with a one-cycle turnaround between owners.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module sram_arbiter #(
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Req0_request,
  output logic        Req0_grant,
  input  logic [17:0] Req0_address,
  input  logic [15:0] Req0_write_data,
  input  logic        Req0_we_n,
  output logic [15:0] Req0_read_data,
  output logic        Req0_read_valid,
  input  logic        Req1_request,
  output logic        Req1_grant,
  input  logic [17:0] Req1_address,
  input  logic [15:0] Req1_write_data,
  input  logic        Req1_we_n,
  output logic [15:0] Req1_read_data,
  output logic        Req1_read_valid,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN0,
    S_OWN1,
    S_TURN
  } state_e;

  state_e state_q, state_d;

  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [READ_LATENCY-1:0] rd_id_q, rd_id_d;

  logic any_req;
  logic pick1;
  logic owned;

  assign any_req = Req0_request | Req1_request;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;

  // On a tie, hand the SRAM to whoever did not own it last.
  assign pick1 = (Req0_request & Req1_request) ? ~last_q
                                               : ~Req0_request;

  always_comb begin
    last_d = last_q;
    if (state_d == S_OWN0) last_d = 1'b0;
    if (state_d == S_OWN1) last_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) last_q <= 1'b0;
    else         last_q <= last_d;
  end
`else
  assign pick1 = ~Req0_request;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_TURN: begin
        if (any_req) state_d = pick1 ? S_OWN1 : S_OWN0;
        else         state_d = S_IDLE;
      end
      S_OWN0: if (!Req0_request) state_d = S_TURN;
      S_OWN1: if (!Req1_request) state_d = S_TURN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    unique case (state_q)
      S_OWN0: begin
        SRAM_address    = Req0_address;
        SRAM_write_data = Req0_write_data;
        SRAM_we_n       = Req0_we_n;
      end
      S_OWN1: begin
        SRAM_address    = Req1_address;
        SRAM_write_data = Req1_write_data;
        SRAM_we_n       = Req1_we_n;
      end
      default: ;
    endcase
  end

  assign owned = (state_q == S_OWN0) | (state_q == S_OWN1);

  // Tag each issued read with its owner so it returns to the right port.
  always_comb begin
    rd_vld_d    = '0;
    rd_id_d     = '0;
    rd_vld_d[0] = owned & SRAM_we_n;
    rd_id_d[0]  = (state_q == S_OWN1);
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_id_d[i]  = rd_id_q[i-1];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      rd_vld_q <= '0;
      rd_id_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
    end
  end

  assign Req0_grant = (state_q == S_OWN0);
  assign Req1_grant = (state_q == S_OWN1);

  assign Req0_read_valid = rd_vld_q[READ_LATENCY-1]
                         & ~rd_id_q[READ_LATENCY-1];
  assign Req1_read_valid = rd_vld_q[READ_LATENCY-1]
                         & rd_id_q[READ_LATENCY-1];

  assign Req0_read_data = SRAM_read_data;
  assign Req1_read_data = SRAM_read_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, ownership/read-tag model, directed vectors.
// Honours SRAM_ARB_RR_EN when the build defines it.
module tb_sram_arbiter;

  localparam int L = 2;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        Clock;
  logic        Resetn;
  logic        Req0_request, Req0_grant, Req0_we_n, Req0_read_valid;
  logic [17:0] Req0_address;
  logic [15:0] Req0_write_data, Req0_read_data;
  logic        Req1_request, Req1_grant, Req1_we_n, Req1_read_valid;
  logic [17:0] Req1_address;
  logic [15:0] Req1_write_data, Req1_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data, SRAM_read_data;
  logic        SRAM_we_n;

  sram_arbiter #(.READ_LATENCY(L)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Req0_request(Req0_request), .Req0_grant(Req0_grant),
    .Req0_address(Req0_address), .Req0_write_data(Req0_write_data),
    .Req0_we_n(Req0_we_n), .Req0_read_data(Req0_read_data),
    .Req0_read_valid(Req0_read_valid),
    .Req1_request(Req1_request), .Req1_grant(Req1_grant),
    .Req1_address(Req1_address), .Req1_write_data(Req1_write_data),
    .Req1_we_n(Req1_we_n), .Req1_read_data(Req1_read_data),
    .Req1_read_valid(Req1_read_valid),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Environment SRAM: fixed read latency of L cycles.
  logic [15:0] smem [0:262143];
  logic [15:0] rdp [L];
  logic [15:0] mmem [0:262143];

  initial begin
    for (int i = 0; i < 262144; i++) begin
      smem[i] = 16'd0;
      mmem[i] = 16'd0;
    end
    for (int i = 0; i < L; i++) rdp[i] = 16'd0;
  end

  always @(posedge Clock) begin
    if (!SRAM_we_n) smem[SRAM_address] <= SRAM_write_data;
    rdp[0] <= smem[SRAM_address];
    for (int i = 1; i < L; i++) rdp[i] <= rdp[i-1];
  end

  assign SRAM_read_data = rdp[L-1];

  // Model: who owns the SRAM, and which reads return when and to whom.
  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } rd_t;

  rd_t pend[$];
  int  owner = -1;
  int  last_m = 0;
  int  cyc = 0;

  always @(negedge Clock) begin
    logic        eg0, eg1, ewe, ev0, ev1;
    logic [17:0] ea;
    logic [15:0] ewd, ed;
    cyc++;
    if (!Resetn) begin
      owner  = -1;
      last_m = 0;
      pend.delete();
    end
    eg0 = (owner == 0);
    eg1 = (owner == 1);
    ea  = eg0 ? Req0_address : eg1 ? Req1_address : 18'd0;
    ewd = eg0 ? Req0_write_data : eg1 ? Req1_write_data : 16'd0;
    ewe = eg0 ? Req0_we_n : eg1 ? Req1_we_n : 1'b1;
    ev0 = 1'b0;
    ev1 = 1'b0;
    ed  = 16'd0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev0 = (pend[0].id == 0);
      ev1 = (pend[0].id == 1);
      ed  = pend[0].data;
      pend.delete(0);
    end
    chk("m_grant0", Req0_grant, eg0);
    chk("m_grant1", Req1_grant, eg1);
    chk("m_addr", SRAM_address, ea);
    chk("m_wdata", SRAM_write_data, ewd);
    chk("m_we_n", SRAM_we_n, ewe);
    chk("m_rvalid0", Req0_read_valid, ev0);
    chk("m_rvalid1", Req1_read_valid, ev1);
    if (ev0) chk("m_rdata0", Req0_read_data, ed);
    if (ev1) chk("m_rdata1", Req1_read_data, ed);
    if (Resetn) begin
      if (owner >= 0) begin
        if (ewe) pend.push_back('{cyc + L, owner, mmem[ea]});
        else     mmem[ea] = ewd;
        if (!(owner == 0 ? Req0_request : Req1_request)) owner = -1;
      end else begin
        if (Req0_request && Req1_request)
          owner = RR ? (last_m == 0 ? 1 : 0) : 0;
        else if (Req0_request) owner = 0;
        else if (Req1_request) owner = 1;
        if (owner >= 0) last_m = owner;
      end
    end
  end

  task automatic bus(input logic r0, input logic w0n,
                     input logic [17:0] a0, input logic [15:0] d0,
                     input logic r1, input logic w1n,
                     input logic [17:0] a1, input logic [15:0] d1);
    Req0_request    = r0;
    Req0_we_n       = w0n;
    Req0_address    = a0;
    Req0_write_data = d0;
    Req1_request    = r1;
    Req1_we_n       = w1n;
    Req1_address    = a1;
    Req1_write_data = d1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Resetn = 1'b0;
    bus(0, 1, 0, 0, 0, 1, 0, 0);
    tick();
    tick();
    @(negedge Clock);
    chk("rst_g0", Req0_grant, 0);
    chk("rst_g1", Req1_grant, 0);
    chk("rst_we_n", SRAM_we_n, 1);
    chk("rst_addr", SRAM_address, 0);
    tick();
    Resetn = 1'b1;
    tick();

    // Req0 alone: four writes, then four reads ending the burst.
    bus(1, 0, 0, 0, 0, 1, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus(1, 0, 18'(i), 16'(i), 0, 1, 0, 0);
      @(negedge Clock);
      chk("a_wr_we_n", SRAM_we_n, 0);
      chk("a_wr_g0", Req0_grant, 1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      bus(i != 3, 1, 18'(i), 0, 0, 1, 0, 0);
      @(negedge Clock);
      chk("a_rd_we_n", SRAM_we_n, 1);
      if (i >= 2) begin
        chk("a_rv0", Req0_read_valid, 1);
        chk("a_rdata", Req0_read_data, i - 2);
      end else begin
        chk("a_rv0_early", Req0_read_valid, 0);
      end
      tick();
    end
    bus(0, 1, 0, 0, 0, 1, 0, 0);
    @(negedge Clock);
    chk("a_turn_g0", Req0_grant, 0);
    chk("a_rdata2", Req0_read_data, 2);
    tick();
    @(negedge Clock);
    chk("a_rv0_last", Req0_read_valid, 1);
    chk("a_rdata3", Req0_read_data, 3);
    tick();
    @(negedge Clock);
    chk("a_rv0_done", Req0_read_valid, 0);

    // Simultaneous requests from idle, then a tie during the turnaround.
    bus(1, 1, 1, 0, 1, 1, 2, 0);
    tick();
    @(negedge Clock);
    chk("b_first_g0", Req0_grant, !RR);
    chk("b_first_g1", Req1_grant, RR);
    tick();
    bus(RR, 1, 1, 0, !RR, 1, 2, 0);
    @(negedge Clock);
    chk("b_hold", RR ? Req1_grant : Req0_grant, 1);
    tick();
    bus(1, 1, 1, 0, 1, 1, 2, 0);
    @(negedge Clock);
    chk("b_turn_g0", Req0_grant, 0);
    chk("b_turn_g1", Req1_grant, 0);
    chk("b_turn_addr", SRAM_address, 0);
    tick();
    bus(0, 1, 1, 0, 1, 1, 2, 0);
    @(negedge Clock);
    chk("b_tie_g0", Req0_grant, 1);
    chk("b_tie_g1", Req1_grant, 0);
    tick();
    @(negedge Clock);
    chk("b_turn2_g1", Req1_grant, 0);
    tick();
    bus(0, 1, 1, 0, 0, 1, 2, 0);
    @(negedge Clock);
    chk("b_late_g1", Req1_grant, 1);
    tick();
    tick();

    // Req0's last-cycle read lands during Req1's ownership.
    bus(1, 0, 18'h3ffff, 16'hbeef, 0, 1, 0, 0);
    tick();
    @(negedge Clock);
    chk("c_wr_g0", Req0_grant, 1);
    tick();
    bus(0, 1, 18'h3ffff, 0, 1, 0, 10, 16'h1234);
    @(negedge Clock);
    chk("c_rd_addr", SRAM_address, 18'h3ffff);
    tick();
    @(negedge Clock);
    chk("c_turn_rv0", Req0_read_valid, 0);
    tick();
    @(negedge Clock);
    chk("c_own1_g1", Req1_grant, 1);
    chk("c_tag_rv0", Req0_read_valid, 1);
    chk("c_tag_rv1", Req1_read_valid, 0);
    chk("c_tag_data", Req0_read_data, 16'hbeef);
    tick();
    bus(0, 1, 0, 0, 0, 1, 10, 0);
    tick();
    @(negedge Clock);
    chk("c_rv1_wait", Req1_read_valid, 0);
    tick();
    @(negedge Clock);
    chk("c_rv1", Req1_read_valid, 1);
    chk("c_rdata1", Req1_read_data, 16'h1234);
    tick();

    // Reset with two of Req1's reads in flight.
    bus(0, 1, 0, 0, 1, 1, 0, 0);
    tick();
    @(negedge Clock);
    chk("d_g1", Req1_grant, 1);
    tick();
    bus(0, 1, 0, 0, 1, 1, 1, 0);
    tick();
    Resetn = 1'b0;
    bus(0, 1, 0, 0, 1, 0, 20, 0);
    @(negedge Clock);
    chk("d_rst_g1", Req1_grant, 0);
    chk("d_rst_rv1", Req1_read_valid, 0);
    chk("d_rst_we_n", SRAM_we_n, 1);
    tick();
    Resetn = 1'b1;
    @(negedge Clock);
    chk("d_rel_rv1", Req1_read_valid, 0);
    chk("d_rel_g1", Req1_grant, 0);
    tick();
    bus(0, 1, 0, 0, 0, 0, 20, 0);
    @(negedge Clock);
    chk("d_regrant", Req1_grant, 1);
    tick();
    tick();

    // Req1 requests for a single cycle.
    bus(0, 1, 0, 0, 1, 0, 30, 5);
    tick();
    bus(0, 1, 0, 0, 0, 0, 30, 5);
    @(negedge Clock);
    chk("e_own_g1", Req1_grant, 1);
    chk("e_own_we_n", SRAM_we_n, 0);
    tick();
    @(negedge Clock);
    chk("e_turn_g1", Req1_grant, 0);
    chk("e_turn_we_n", SRAM_we_n, 1);
    tick();
    @(negedge Clock);
    chk("e_idle_g1", Req1_grant, 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
